// File: rtl/rmii_rx_deframer_if.sv
// Byte-stream side of the RMII receive deframer: assembled bytes plus
// start/end/error framing markers.
//
// Handshake: rx_valid is a one-clock strobe with no ready/backpressure; the
// consumer must take rx_data/rx_sof in that cycle. rx_eof is a separate
// one-clock strobe (never together with rx_valid) qualified by rx_err/rx_len.
interface rmii_rx_deframer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_err;
  logic [10:0] rx_len;
  logic        rx_active;

  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_len, rx_active
  );

  modport slave (
    input rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_len, rx_active
  );
endinterface

// File: rtl/rmii_rx_deframer.sv
// RMII receive front end: samples CRS_DV/RXD at REF_CLK, tolerates end-of-carrier
// CRS_DV toggling, strips preamble/SFD and emits framed bytes.
module rmii_rx_deframer #(
  parameter int MAX_BYTES = 1522
) (
  input  logic                      REF_CLK,
  input  logic                      arst_n,
  input  logic                      CRS_DV,
  input  logic                      RXD0,
  input  logic                      RXD1,
  rmii_rx_deframer_if.master        rx,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_DISCARD  = 2'd0,
    S_IDLE     = 2'd1,
    S_PREAMBLE = 2'd2,
    S_DATA     = 2'd3
  } state_t;

  localparam logic [10:0] MAX_LEN = 11'(MAX_BYTES);

  state_t      state;
  logic        s_valid;
  logic        s_crs;
  logic [1:0]  s_dibit;
  logic [5:0]  byte_buf;
  logic [1:0]  idx;
  logic [10:0] count;
  logic        sof_pend;
  logic        commit;
  logic        carrier_end;

  // The held sample commits unless it and the current sample are both low;
  // that double-low is the only thing that ends a carrier.
  assign commit      = s_valid & (s_crs | CRS_DV);
  assign carrier_end = s_valid & ~s_crs & ~CRS_DV;
  assign dbg_state   = state;

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      state        <= S_DISCARD;
      s_valid      <= 1'b0;
      s_crs        <= 1'b0;
      s_dibit      <= 2'b00;
      byte_buf     <= 6'd0;
      idx          <= 2'd0;
      count        <= 11'd0;
      sof_pend     <= 1'b0;
      rx.rx_data   <= 8'h00;
      rx.rx_valid  <= 1'b0;
      rx.rx_sof    <= 1'b0;
      rx.rx_eof    <= 1'b0;
      rx.rx_err    <= 1'b0;
      rx.rx_len    <= 11'd0;
      rx.rx_active <= 1'b0;
    end else begin
      s_valid     <= 1'b1;
      s_crs       <= CRS_DV;
      s_dibit     <= {RXD1, RXD0};
      rx.rx_valid <= 1'b0;
      rx.rx_sof   <= 1'b0;
      rx.rx_eof   <= 1'b0;
      rx.rx_err   <= 1'b0;
      rx.rx_len   <= 11'd0;

      case (state)
        S_DISCARD: begin
          if (carrier_end) state <= S_IDLE;
        end

        S_IDLE: begin
          if (commit) begin
            if (s_dibit == 2'b01) state <= S_PREAMBLE;
            else if (s_dibit[1])  state <= S_DISCARD;
          end
        end

        S_PREAMBLE: begin
          if (carrier_end) begin
            state <= S_IDLE;
          end else if (commit) begin
            if (s_dibit == 2'b11) begin
              state        <= S_DATA;
              count        <= 11'd0;
              idx          <= 2'd0;
              sof_pend     <= 1'b1;
              rx.rx_active <= 1'b1;
            end else if (s_dibit != 2'b01) begin
              state <= S_DISCARD;
            end
          end
        end

        S_DATA: begin
          if (carrier_end) begin
            state        <= S_IDLE;
            rx.rx_active <= 1'b0;
            // An SFD with no whole byte behind it is treated as no frame at all.
            if (count != 11'd0) begin
              rx.rx_eof <= 1'b1;
              rx.rx_err <= (idx != 2'd0);
              rx.rx_len <= count;
            end
          end else if (commit) begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0: byte_buf[1:0] <= s_dibit;
              2'd1: byte_buf[3:2] <= s_dibit;
              2'd2: byte_buf[5:4] <= s_dibit;
              default: begin
                if (count == MAX_LEN) begin
                  rx.rx_eof    <= 1'b1;
                  rx.rx_err    <= 1'b1;
                  rx.rx_len    <= MAX_LEN;
                  rx.rx_active <= 1'b0;
                  state        <= S_DISCARD;
                end else begin
                  rx.rx_valid <= 1'b1;
                  rx.rx_data  <= {s_dibit, byte_buf};
                  rx.rx_sof   <= sof_pend;
                  sof_pend    <= 1'b0;
                  count       <= count + 11'd1;
                end
              end
            endcase
          end
        end

        default: state <= S_DISCARD;
      endcase
    end
  end

endmodule

// File: doc/rmii_rx_deframer.md
# rmii_rx_deframer

Receive-side front end of the RMII repeater: samples a PHY's CRS_DV/RXD0/RXD1 at 100 Mb/s, strips preamble and SFD, and delivers the frame as a byte stream with start/end/error markers. Handles RMII CRS_DV end-of-carrier toggling. One instance per PHY port, between the PHY pins and the repeater's transmit-side buffering.

## Interface
- MAX_BYTES, 1522: largest accepted frame in bytes after SFD; legal range 64..2047.

- REF_CLK  in  1  50 MHz RMII reference clock; all logic on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- CRS_DV  in  1  RMII carrier-sense/data-valid.
- RXD0  in  1  RMII receive data, LSB of dibit.
- RXD1  in  1  RMII receive data, MSB of dibit.
- rx_data  out  8  assembled byte; valid only while rx_valid=1.
- rx_valid  out  1  one-clock strobe per byte.
- rx_sof  out  1  high with rx_valid of the first byte after SFD.
- rx_eof  out  1  one-clock end-of-frame strobe; never coincident with rx_valid.
- rx_err  out  1  qualifies rx_eof: 1 = bad frame (misaligned or oversize).
- rx_len  out  11  byte count delivered, valid while rx_eof=1.
- rx_active  out  1  high while in DATA state.

## Operation
- Dibit = {RXD1,RXD0}, sampled every REF_CLK edge.
- Commit rule, handling CRS_DV toggling:
  - dibit sampled with CRS_DV=1: committed at the next edge;
  - dibit sampled with CRS_DV=0: held pending; committed at the next edge if CRS_DV=1 there;
  - two consecutive CRS_DV=0 samples: the pending dibit is discarded and a carrier-end event is raised at the second edge.
- State machine on the committed stream:
  - DISCARD (reset state): ignore dibits; carrier-end -> IDLE; an already-low line also reaches IDLE after two low samples.
  - IDLE: 00 -> stay; 01 -> PREAMBLE; 10 or 11 -> DISCARD (false carrier).
  - PREAMBLE: 01 -> stay; 11 (SFD) -> DATA, byte count=0, dibit index=0; 00/10 -> DISCARD; carrier-end -> IDLE with no output.
  - DATA: dibit k of a byte goes to rx_data bits [2k+1:2k], k=0..3, so the first dibit is the LSBs. The 4th dibit emits the byte and increments the count.
- End of frame in DATA on carrier-end:
  - dibit index 0 and count>0: rx_eof=1, rx_err=0, rx_len=count;
  - dibit index ≠0: partial byte dropped; rx_eof=1, rx_err=1, rx_len=count of whole bytes;
  - count=0 (SFD then carrier-end): no rx_eof and no rx_sof; go to IDLE.
- Oversize: if a byte would make count > MAX_BYTES, that byte is not emitted. rx_eof=1, rx_err=1, rx_len=MAX_BYTES, then DISCARD until carrier-end.
- rx_sof is asserted only once per frame.

## Timing
- Reset: all outputs 0, rx_data=0x00, state DISCARD, pending dibit cleared.
- Byte latency: if a byte's 4th dibit is sampled at edge N, rx_valid, rx_data and rx_sof are registered at edge N+1. The commit, shift and emit happen in a single edge.
- Minimum spacing between rx_valid strobes is 4 clocks.
- rx_eof is registered at the edge that detects carrier-end, or at the edge where the overflowing byte would have been emitted.
- Last byte followed by carrier loss: rx_valid at N+1, CRS_DV low at N+1 and N+2, rx_eof at N+2.
- rx_active falls at the same edge rx_eof rises.
- Reset asserted mid-frame: outputs clear immediately and no rx_eof is issued. After release, a carrier still high is ignored (DISCARD) until two low samples.
- A single CRS_DV low sample inside a frame never ends it. The toggle pattern (low, high, low, high, ...) with valid data must yield intact bytes.

## Test plan
- CRS_DV=1, dibits 01,01,01,11, then 01 for 64×4 clocks, then CRS_DV=0 -> 64 rx_valid with rx_data=0x55, rx_sof on the first, then rx_eof=1, rx_err=0, rx_len=64.
- Payload bytes 0xA5, 0x3C (dibits 01,01,10,10,00,11,11,00) -> rx_data 0xA5 then 0x3C, each exactly 1 clock after its 4th dibit.
- Carrier drop after 10 bytes + 2 dibits -> rx_eof=1, rx_err=1, rx_len=10.
- Ten bytes, then 16 clocks of CRS_DV toggling low/high with data 01, then two lows -> 14 bytes of 0x55, clean rx_eof with rx_len=14.
- MAX_BYTES=64 with a 70-byte frame -> 64 bytes, then rx_eof with rx_err=1 and rx_len=64; no further output until carrier ends; the next frame is received normally.
- Reset pulsed mid-frame with CRS_DV held high -> no output until CRS_DV is low ≥2 clocks; a following frame with dibits 00,00,10 after preamble start is dropped as false carrier.
